dsp48a1_mac_sequencer: RTL and testbench

- Controller that runs one DSP48A1 slice as a vector multiply-accumulate engine: P = sum over i of A[i]*B[i].
- Accepts a job of length len over a valid/ready handshake, then accepts one operand pair per handshake.
- Drives the slice's OPMODE, clock enables and P reset, aligned to the slice's configured pipeline depth; signals completion over valid/ready.
- The A/B operand buses go straight from the requester to the slice; this block only handshakes and sequences.

---
 rtl/dsp48a1_mac_sequencer_if.sv | 32 +++
 rtl/dsp48a1_mac_sequencer.sv | 150 +++++++++++++++
 tb/tb_dsp48a1_mac_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp48a1_mac_sequencer_if.sv
// Handshake and slice-control bundle between a MAC requester, the sequencer and a DSP48A1 slice.
interface dsp48a1_mac_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] len;
    logic             op_valid;
    logic             op_ready;
    logic             ce_ab;
    logic             ce_m;
    logic             ce_p;
    logic             rst_p;
    logic [7:0]       opmode;
    logic             done_valid;
    logic             done_ready;
    logic             busy;

    modport master (
        output start_valid, len, op_valid, done_ready,
        input  start_ready, op_ready, done_valid, busy
    );

    modport slave (
        input  start_valid, len, op_valid, done_ready,
        output start_ready, op_ready, ce_ab, ce_m, ce_p, rst_p, opmode, done_valid, busy
    );

    modport slice (
        input ce_ab, ce_m, ce_p, rst_p, opmode
    );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Sequences one DSP48A1 slice (PREG=1, OPMODEREG=0) through a vector multiply-accumulate job.
// A {valid, first} tag pipe of depth IN_REG+MREG lines up OPMODE/CE_P with products reaching the post-adder.
module dsp48a1_mac_sequencer #(
    parameter int IN_REG = 1,
    parameter int MREG   = 1,
    parameter int CNT_W  = 8
) (
    input logic CLK,
    input logic RST_n,
    dsp48a1_mac_sequencer_if.slave bus
);
    localparam int unsigned D = IN_REG + MREG;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             first_q, first_d;

    logic start_acc;
    logic op_acc;
    logic tag_in_valid;
    logic tag_in_first;
    logic tail_valid;
    logic tail_first;
    logic pipe_busy;

    assign start_acc    = RST_n && (state_q == IDLE) && bus.start_valid;
    assign op_acc       = RST_n && (state_q == RUN) && bus.op_valid;
    assign tag_in_valid = op_acc;
    assign tag_in_first = op_acc && first_q;

    if (D == 0) begin : g_nopipe
        assign tail_valid = tag_in_valid;
        assign tail_first = tag_in_first;
        assign pipe_busy  = 1'b0;
    end else begin : g_pipe
        logic [D-1:0] vld_q;
        logic [D-1:0] fst_q;

        always_ff @(posedge CLK) begin
            if (!RST_n) begin
                vld_q <= '0;
                fst_q <= '0;
            end else if (state_q == RUN || state_q == DRAIN) begin
                vld_q[0] <= tag_in_valid;
                fst_q[0] <= tag_in_first;
                for (int unsigned i = 1; i < D; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    fst_q[i] <= fst_q[i-1];
                end
            end
        end

        assign tail_valid = vld_q[D-1];
        assign tail_first = fst_q[D-1];

        // Any valid tag still behind the tail means the drain is not finished.
        always_comb begin
            pipe_busy = 1'b0;
            for (int unsigned i = 0; i + 1 < D; i++) begin
                pipe_busy = pipe_busy | vld_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        first_d         = first_q;
        bus.start_ready = 1'b0;
        bus.op_ready    = 1'b0;
        bus.ce_ab       = 1'b0;
        bus.ce_m        = 1'b0;
        bus.rst_p       = 1'b0;
        bus.done_valid  = 1'b0;
        bus.busy        = 1'b0;

        if (!RST_n) begin
            bus.rst_p = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    bus.start_ready = 1'b1;
                    if (start_acc) begin
                        bus.rst_p   = 1'b1;
                        remaining_d = bus.len;
                        first_d     = 1'b1;
                        state_d     = (bus.len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    bus.op_ready = 1'b1;
                    bus.ce_ab    = 1'b1;
                    bus.ce_m     = 1'b1;
                    bus.busy     = 1'b1;
                    if (op_acc) begin
                        remaining_d = remaining_q - 1'b1;
                        first_d     = 1'b0;
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = (D > 0) ? DRAIN : DONE;
                        end
                    end
                end
                DRAIN: begin
                    bus.ce_ab = 1'b1;
                    bus.ce_m  = 1'b1;
                    bus.busy  = 1'b1;
                    if (tail_valid && !pipe_busy) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    bus.done_valid = 1'b1;
                    bus.busy       = 1'b1;
                    if (bus.done_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ce_p   = 1'b0;
        bus.opmode = 8'h00;
        if (RST_n && (state_q == RUN || state_q == DRAIN) && tail_valid) begin
            bus.ce_p   = 1'b1;
            bus.opmode = tail_first ? 8'h01 : 8'h09;
        end
    end
endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench: two sequencer configurations, each driving a behavioural DSP48A1 slice model; P checked via a scoreboard.
module tb_dsp48a1_mac_sequencer;
    localparam int CNT_W = 8;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    logic             sel = 1'b0;
    logic             sv = 1'b0;
    logic             opv = 1'b0;
    logic             dr = 1'b0;
    logic [CNT_W-1:0] ln = '0;
    logic [17:0]      A = '0;
    logic [17:0]      B = '0;

    dsp48a1_mac_sequencer_if #(.CNT_W(CNT_W)) b1 ();
    dsp48a1_mac_sequencer_if #(.CNT_W(CNT_W)) b0 ();

    dsp48a1_mac_sequencer #(.IN_REG(1), .MREG(1), .CNT_W(CNT_W)) u1 (
        .CLK(CLK), .RST_n(RST_n), .bus(b1)
    );
    dsp48a1_mac_sequencer #(.IN_REG(0), .MREG(0), .CNT_W(CNT_W)) u0 (
        .CLK(CLK), .RST_n(RST_n), .bus(b0)
    );

    assign b1.start_valid = !sel && sv;
    assign b1.op_valid    = !sel && opv;
    assign b1.done_ready  = !sel && dr;
    assign b1.len         = ln;
    assign b0.start_valid = sel && sv;
    assign b0.op_valid    = sel && opv;
    assign b0.done_ready  = sel && dr;
    assign b0.len         = ln;

    function automatic logic [47:0] post_add(input logic [7:0] op, input logic [35:0] m,
                                             input logic [47:0] p);
        logic [47:0] x;
        logic [47:0] z;
        x = (op[1:0] == 2'b01) ? {12'd0, m} : 48'd0;
        z = (op[3:2] == 2'b10) ? p : 48'd0;
        return x + z;
    endfunction

    // Slice with AREG=BREG=1, MREG=1, PREG=1
    logic [17:0] a1_q = '0;
    logic [17:0] bb1_q = '0;
    logic [35:0] m1_q = '0;
    logic [47:0] p1 = '0;
    always @(posedge CLK) begin
        if (b1.ce_ab) begin
            a1_q  <= A;
            bb1_q <= B;
        end
        if (b1.ce_m) m1_q <= 36'(a1_q) * 36'(bb1_q);
        if (b1.rst_p) p1 <= '0;
        else if (b1.ce_p) p1 <= post_add(b1.opmode, m1_q, p1);
    end

    // Slice with no input or multiplier registers, PREG=1
    logic [35:0] m0;
    logic [47:0] p0 = '0;
    assign m0 = 36'(A) * 36'(B);
    always @(posedge CLK) begin
        if (b0.rst_p) p0 <= '0;
        else if (b0.ce_p) p0 <= post_add(b0.opmode, m0, p0);
    end

    logic        s_start_ready, s_op_ready, s_ce_p, s_rst_p, s_done_valid, s_busy;
    logic [7:0]  s_opmode;
    logic [47:0] s_p;
    assign s_start_ready = sel ? b0.start_ready : b1.start_ready;
    assign s_op_ready    = sel ? b0.op_ready    : b1.op_ready;
    assign s_ce_p        = sel ? b0.ce_p        : b1.ce_p;
    assign s_rst_p       = sel ? b0.rst_p       : b1.rst_p;
    assign s_done_valid  = sel ? b0.done_valid  : b1.done_valid;
    assign s_busy        = sel ? b0.busy        : b1.busy;
    assign s_opmode      = sel ? b0.opmode      : b1.opmode;
    assign s_p           = sel ? p0             : p1;

    typedef struct {
        int         due;
        logic [7:0] op;
    } tag_t;

    tag_t        tq[$];
    logic [47:0] pq[$];
    int          cyc = 0;
    int          ncmp = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Every cycle: ce_p/opmode must match the tag scheduled for this cycle, or be idle.
    task automatic settle_check();
        tag_t t;
        #1;
        if (tq.size() > 0 && tq[0].due == cyc) begin
            t = tq.pop_front();
            chk("ce_p", 64'(s_ce_p), 64'd1);
            chk("opmode", 64'(s_opmode), 64'(t.op));
        end else begin
            chk("ce_p_idle", 64'(s_ce_p), 64'd0);
            chk("opmode_idle", 64'(s_opmode), 64'd0);
        end
    endtask

    task automatic run_job(input int n, input int a[4], input int b[4], input int gap[4],
                           input int hold);
        int          d;
        int          last;
        int          start_cyc;
        bit          got;
        logic [47:0] expp;
        logic [47:0] res;
        d    = sel ? 0 : 2;
        expp = '0;
        for (int i = 0; i < n; i++) expp += 48'(a[i] * b[i]);
        pq.push_back(expp);

        sv = 1'b1;
        ln = CNT_W'(n);
        settle_check();
        chk("start_ready", 64'(s_start_ready), 64'd1);
        chk("rst_p_pulse", 64'(s_rst_p), 64'd1);
        start_cyc = cyc;
        last      = cyc;
        next();
        sv = 1'b0;

        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                opv = 1'b0;
                settle_check();
                chk("busy_run", 64'(s_busy), 64'd1);
                next();
            end
            opv = 1'b1;
            A   = 18'(a[i]);
            B   = 18'(b[i]);
            tq.push_back('{cyc + d, (i == 0) ? 8'h01 : 8'h09});
            settle_check();
            chk("op_ready", 64'(s_op_ready), 64'd1);
            chk("rst_p_run", 64'(s_rst_p), 64'd0);
            last = cyc;
            next();
        end
        opv = 1'b0;
        dr  = (hold == 0);

        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            settle_check();
            if (s_done_valid) got = 1'b1;
            else next();
        end
        chk("done_seen", 64'(got), 64'd1);
        if (n > 0) chk("done_latency", 64'(cyc - last), 64'(d + 1));
        else       chk("done_latency_len0", 64'(cyc - start_cyc), 64'd1);
        res = pq.pop_front();
        chk("result_p", 64'(s_p), 64'(res));
        chk("done_start_ready", 64'(s_start_ready), 64'd0);

        for (int h = 0; h < hold; h++) begin
            next();
            sv = 1'b1;
            settle_check();
            chk("hold_done_valid", 64'(s_done_valid), 64'd1);
            chk("hold_p", 64'(s_p), 64'(res));
            chk("hold_start_ready", 64'(s_start_ready), 64'd0);
        end
        sv = 1'b0;
        dr = 1'b1;
        next();
        dr = 1'b0;
        settle_check();
        chk("idle_start_ready", 64'(s_start_ready), 64'd1);
        chk("idle_done_valid", 64'(s_done_valid), 64'd0);
        chk("idle_busy", 64'(s_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ja[4];
        int jb[4];
        int jg[4];

        // Reset state on both instances
        next();
        #1;
        chk("rst_rst_p_1", 64'(b1.rst_p), 64'd1);
        chk("rst_start_ready_1", 64'(b1.start_ready), 64'd0);
        chk("rst_busy_1", 64'(b1.busy), 64'd0);
        chk("rst_rst_p_0", 64'(b0.rst_p), 64'd1);
        chk("rst_start_ready_0", 64'(b0.start_ready), 64'd0);
        chk("rst_ce_p_0", 64'(b0.ce_p), 64'd0);
        next();
        RST_n = 1'b1;
        settle_check();
        chk("post_rst_start_ready", 64'(s_start_ready), 64'd1);
        chk("post_rst_rst_p", 64'(s_rst_p), 64'd0);
        chk("post_rst_op_ready", 64'(s_op_ready), 64'd0);
        next();

        // Back-to-back job
        ja = '{2, 3, 4, 0};
        jb = '{5, 6, 7, 0};
        jg = '{0, 0, 0, 0};
        run_job(3, ja, jb, jg, 0);
        next();

        // Two bubbles between pairs 1 and 2
        jg = '{0, 2, 0, 0};
        run_job(3, ja, jb, jg, 0);
        next();

        // Zero-length job
        jg = '{0, 0, 0, 0};
        run_job(0, ja, jb, jg, 0);
        next();

        // done_ready held low for 5 cycles
        run_job(3, ja, jb, jg, 5);
        next();

        // Reset after the second accept of a len=4 job
        sv = 1'b1;
        ln = CNT_W'(4);
        settle_check();
        next();
        sv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            opv = 1'b1;
            A   = 18'(i + 5);
            B   = 18'(i + 7);
            tq.push_back('{cyc + 2, (i == 0) ? 8'h01 : 8'h09});
            settle_check();
            next();
        end
        opv   = 1'b0;
        RST_n = 1'b0;
        tq.delete();
        settle_check();
        chk("midrst_rst_p", 64'(s_rst_p), 64'd1);
        chk("midrst_busy", 64'(s_busy), 64'd0);
        chk("midrst_done_valid", 64'(s_done_valid), 64'd0);
        chk("midrst_op_ready", 64'(s_op_ready), 64'd0);
        next();
        RST_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle_check();
            chk("abandoned_no_done", 64'(s_done_valid), 64'd0);
            chk("abandoned_idle", 64'(s_start_ready), 64'd1);
            next();
        end
        ja = '{3, 0, 0, 0};
        jb = '{3, 0, 0, 0};
        run_job(1, ja, jb, jg, 0);
        next();

        // Unregistered configuration
        sel = 1'b1;
        settle_check();
        chk("cfg0_idle", 64'(s_start_ready), 64'd1);
        next();
        ja = '{1, 2, 0, 0};
        jb = '{1, 2, 0, 0};
        run_job(2, ja, jb, jg, 0);
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
